// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_sequencer_pkg;

  // Width of the HOLD/GAP cycle counter.
  localparam int unsigned CntWidth = 16;

  // Sequencer states. Encoding 2'd3 is unused and recovers to StHold.
  typedef enum logic [1:0] {
    StHold = 2'd0,
    StGap  = 2'd1,
    StRun  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/reset_sequencer_sync.sv
// Multi-flop synchronizer for one asynchronous single-bit input.
// The flops clear synchronously to 0 while i_rst is high.
module reset_sequencer_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: holds peripheral and core resets until the PLL is
// locked and the board button is released, then releases peripherals first and
// the core STAGE_GAP cycles later.
// Optional feature: define RST_SEQ_DEBOUNCE_EN to filter the button input.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned STAGE_GAP       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       pll_locked_i,
  input  logic       ext_rst_ni,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       rst_done_o,
  output logic [1:0] seq_state_o
);

  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HOLD_CYCLES - 1);
  localparam logic [CntWidth-1:0] GapLast  = CntWidth'(STAGE_GAP - 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
      STAGE_GAP < 1 || STAGE_GAP > 65535 || DEBOUNCE_CYCLES < 1 ||
      DEBOUNCE_CYCLES > 65535) begin : g_param_check
    $error("reset_sequencer: parameter out of legal range");
  end

  logic w_lock_sync;
  logic w_btn_sync;
  logic w_btn_released;
  logic w_inputs_ok;

  reset_sequencer_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_lock (
    .i_clk (clk_sys),
    .i_rst (rst_sys),
    .i_d   (pll_locked_i),
    .o_q   (w_lock_sync)
  );

  reset_sequencer_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_btn (
    .i_clk (clk_sys),
    .i_rst (rst_sys),
    .i_d   (ext_rst_ni),
    .o_q   (w_btn_sync)
  );

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam logic [CntWidth-1:0] DbLast = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic                r_btn_filt;
  logic [CntWidth-1:0] r_db_cnt;

  // Accept a new button level only after it differs from the filtered level
  // for DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_btn_filt <= 1'b0;
      r_db_cnt   <= '0;
    end else if (w_btn_sync != r_btn_filt) begin
      if (r_db_cnt == DbLast) begin
        r_btn_filt <= w_btn_sync;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CntWidth'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  assign w_btn_released = r_btn_filt;
`else
  assign w_btn_released = w_btn_sync;
`endif

  assign w_inputs_ok = w_lock_sync & w_btn_released;

  seq_state_e          r_state;
  logic [CntWidth-1:0] r_cnt;
  logic                r_periph_n;
  logic                r_core_n;
  logic                r_done;

  // Sequencer FSM; outputs are loaded from the next-state decode so they
  // switch on the same edge as the state.
  always_ff @(posedge clk_sys) begin
    if (rst_sys || !w_inputs_ok) begin
      r_state    <= StHold;
      r_cnt      <= '0;
      r_periph_n <= 1'b0;
      r_core_n   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        StHold: begin
          if (r_cnt == HoldLast) begin
            r_state    <= StGap;
            r_cnt      <= '0;
            r_periph_n <= 1'b1;
          end else begin
            r_cnt      <= r_cnt + CntWidth'(1);
            r_periph_n <= 1'b0;
          end
          r_core_n <= 1'b0;
          r_done   <= 1'b0;
        end
        StGap: begin
          if (r_cnt == GapLast) begin
            r_state  <= StRun;
            r_cnt    <= '0;
            r_core_n <= 1'b1;
            r_done   <= 1'b1;
          end else begin
            r_cnt    <= r_cnt + CntWidth'(1);
            r_core_n <= 1'b0;
            r_done   <= 1'b0;
          end
          r_periph_n <= 1'b1;
        end
        StRun: begin
          r_cnt      <= '0;
          r_periph_n <= 1'b1;
          r_core_n   <= 1'b1;
          r_done     <= 1'b1;
        end
        default: begin
          r_state    <= StHold;
          r_cnt      <= '0;
          r_periph_n <= 1'b0;
          r_core_n   <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign rst_periph_no = r_periph_n;
  assign rst_core_no   = r_core_n;
  assign rst_done_o    = r_done;
  assign seq_state_o   = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer with default parameters.
// Edge numbering: "edge 0" is the clock edge just before an input is changed;
// the first edge that samples the new value is edge 1.
module tb_reset_sequencer;

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int DbExtra = 4;
`else
  localparam int DbExtra = 0;
`endif

  logic       clk_sys = 1'b0;
  logic       rst_sys;
  logic       pll_locked_i;
  logic       ext_rst_ni;
  logic       rst_periph_no;
  logic       rst_core_no;
  logic       rst_done_o;
  logic [1:0] seq_state_o;

  int n_checks = 0;
  int n_pass   = 0;

  reset_sequencer dut (
    .clk_sys       (clk_sys),
    .rst_sys       (rst_sys),
    .pll_locked_i  (pll_locked_i),
    .ext_rst_ni    (ext_rst_ni),
    .rst_periph_no (rst_periph_no),
    .rst_core_no   (rst_core_no),
    .rst_done_o    (rst_done_o),
    .seq_state_o   (seq_state_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance n edges, leaving time 2 units past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  // Edge index (from the current point) at which each output first reads 1.
  task automatic measure(input int max_edges, output int t_p, output int t_c, output int t_d);
    t_p = -1;
    t_c = -1;
    t_d = -1;
    for (int e = 1; e <= max_edges; e++) begin
      step(1);
      if (t_p < 0 && rst_periph_no) t_p = e;
      if (t_c < 0 && rst_core_no) t_c = e;
      if (t_d < 0 && rst_done_o) t_d = e;
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_periph"}, int'(rst_periph_no), 0);
    check({tag, "_core"}, int'(rst_core_no), 0);
    check({tag, "_done"}, int'(rst_done_o), 0);
    check({tag, "_state"}, int'(seq_state_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tp, tc, td;
    rst_sys      = 1'b1;
    pll_locked_i = 1'b0;
    ext_rst_ni   = 1'b1;
    step(3);
    check_all_low("reset");

    // Power-up: release reset and raise lock together.
    rst_sys      = 1'b0;
    pll_locked_i = 1'b1;
    measure(40, tp, tc, td);
    check("pwrup_periph_edge", tp, 18 + DbExtra);
    check("pwrup_core_edge", tc, 26 + DbExtra);
    check("pwrup_done_edge", td, 26 + DbExtra);
    check("pwrup_state_run", int'(seq_state_o), 2);

    // One-cycle lock drop in RUN.
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    step(1);
    check("drop_e2_periph", int'(rst_periph_no), 1);
    check("drop_e2_core", int'(rst_core_no), 1);
    step(1);
    check_all_low("drop_e3");
    measure(30, tp, tc, td);
    check("drop_periph_rel", tp, 16);
    check("drop_core_rel", tc, 24);
    check("drop_done_rel", td, 24);

    // One-cycle rst_sys pulse in RUN.
    rst_sys = 1'b1;
    step(1);
    check_all_low("rstpulse");
    rst_sys = 1'b0;
    measure(40, tp, tc, td);
    check("rstpulse_periph_edge", tp, 18 + DbExtra);
    check("rstpulse_core_edge", tc, 26 + DbExtra);

    // Lock drop timed so the FSM is in GAP with count 5 when it sees it.
    rst_sys = 1'b1;
    step(1);
    rst_sys = 1'b0;
    step(21 + DbExtra);
    check("gap_entered", int'(seq_state_o), 1);
    pll_locked_i = 1'b0;
    step(2);
    check("gap_cnt5_state", int'(seq_state_o), 1);
    check("gap_cnt5_periph", int'(rst_periph_no), 1);
    check("gap_cnt5_core", int'(rst_core_no), 0);
    step(1);
    check_all_low("gap_abort");
    step(3);
    pll_locked_i = 1'b1;
    measure(40, tp, tc, td);
    check("gap_restart_periph", tp, 18);
    check("gap_restart_core", tc, 26);

    // Button held low with lock high keeps everything in HOLD.
    ext_rst_ni = 1'b0;
    step(10);
    check_all_low("btn_held_a");
    step(60);
    check_all_low("btn_held_b");
    ext_rst_ni = 1'b1;
    measure(40, tp, tc, td);
    check("btn_rel_periph", tp, 18 + DbExtra);
    check("btn_rel_core", tc, 26 + DbExtra);

`ifdef RST_SEQ_DEBOUNCE_EN
    // 3-cycle glitch is filtered; 4-cycle press takes effect.
    ext_rst_ni = 1'b0;
    step(3);
    ext_rst_ni = 1'b1;
    step(12);
    check("glitch_periph", int'(rst_periph_no), 1);
    check("glitch_core", int'(rst_core_no), 1);
    ext_rst_ni = 1'b0;
    step(4);
    ext_rst_ni = 1'b1;
    step(6);
    check("press_periph", int'(rst_periph_no), 0);
    check("press_core", int'(rst_core_no), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
